mem_arbiter: RTL and testbench

- Two-requester arbiter and sequencer in front of the 256x8 single-port data memory (combinational read, synchronous write).
- Requester 0 is the CPU core; requester 1 is an auxiliary client, such as the display/LED pattern fetcher or the debug loader.
- Round-robin grant, one access per grant, registered memory-side bus, and per-port registered read data with a one-cycle ack pulse.

---
 rtl/mem_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port memory; one access per grant.
// Optional MEM_ARB_LOCK_EN adds m0_lock so the CPU can hold the memory across a read-modify-write.
module mem_arbiter #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
`ifdef MEM_ARB_LOCK_EN
    input  logic          m0_lock,
`endif
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_in,
    input  logic [DW-1:0] mem_out
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;

    logic [1:0]    r_state;
    logic          r_last_grant;
    logic          r_owner;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_in;
    logic          r_ack0;
    logic          r_ack1;
    logic [DW-1:0] r_rdata0;
    logic [DW-1:0] r_rdata1;
`ifdef MEM_ARB_LOCK_EN
    logic          r_lock;
`endif

    logic          w_req_any;
    logic          w_owner;
    logic          w_sel_we;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_wdata;

    assign w_req_any = m0_req | m1_req;

    always_comb begin
        w_owner = 1'b0;
        if (m0_req && m1_req) begin
            w_owner = ~r_last_grant;
        end else if (m1_req) begin
            w_owner = 1'b1;
        end
`ifdef MEM_ARB_LOCK_EN
        // A held lock overrides round-robin for the CPU's next request.
        if (r_lock && m0_req) begin
            w_owner = 1'b0;
        end
`endif
    end

    assign w_sel_we    = w_owner ? m1_we    : m0_we;
    assign w_sel_addr  = w_owner ? m1_addr  : m0_addr;
    assign w_sel_wdata = w_owner ? m1_wdata : m0_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_in     <= '0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
`ifdef MEM_ARB_LOCK_EN
            r_lock       <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req_any) begin
                        r_owner    <= w_owner;
                        r_mem_we   <= w_sel_we;
                        r_mem_addr <= w_sel_addr;
                        r_mem_in   <= w_sel_wdata;
                        r_state    <= S_ACC;
`ifdef MEM_ARB_LOCK_EN
                        r_lock     <= 1'b0;
`endif
                    end else begin
                        r_mem_we <= 1'b0;
                    end
                end
                S_ACC: begin
                    // Write commits in memory at this edge; a read captures mem_out.
                    if (!r_mem_we) begin
                        if (r_owner) begin
                            r_rdata1 <= mem_out;
                        end else begin
                            r_rdata0 <= mem_out;
                        end
                    end
                    if (r_owner) begin
                        r_ack1 <= 1'b1;
                    end else begin
                        r_ack0 <= 1'b1;
                    end
                    r_mem_we     <= 1'b0;
                    r_last_grant <= r_owner;
                    r_state      <= S_ACK;
                end
                S_ACK: begin
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
`ifdef MEM_ARB_LOCK_EN
                    r_lock  <= ~r_owner & m0_lock;
`endif
                    r_state <= S_IDLE;
                end
                default: begin
                    r_mem_we <= 1'b0;
                    r_ack0   <= 1'b0;
                    r_ack1   <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign m0_ack   = r_ack0;
    assign m1_ack   = r_ack1;
    assign m0_rdata = r_rdata0;
    assign m1_rdata = r_rdata1;
    assign mem_we   = r_mem_we;
    assign mem_addr = r_mem_addr;
    assign mem_in   = r_mem_in;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected completions are queued at request time
// and popped when an ack appears; a behavioural 256x8 memory sits on the memory bus.
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [7:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
    logic       m0_ack, m1_ack, mem_we;
    logic [7:0] m0_rdata, m1_rdata, mem_addr, mem_in, mem_out;
`ifdef MEM_ARB_LOCK_EN
    logic       m0_lock = 1'b0;
`endif

    always #5 clk = ~clk;

    mem_arbiter #(.AW(8), .DW(8)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
`ifdef MEM_ARB_LOCK_EN
        .m0_lock(m0_lock),
`endif
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_in(mem_in), .mem_out(mem_out)
    );

    function automatic logic [7:0] init_val(input int i);
        case (i)
            8'h17:   return 8'h2F;
            8'hA0:   return 8'hC0;
            8'h40:   return 8'h55;
            8'h41:   return 8'hAA;
            8'h10:   return 8'h3C;
            8'h30:   return 8'h99;
            default: return 8'(i) ^ 8'h5A;
        endcase
    endfunction

    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    assign mem_out = mem[mem_addr];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = init_val(i);
        forever begin
            @(posedge clk);
            if (mem_we) mem[mem_addr] <= mem_in;
        end
    end

    typedef struct packed {
        logic       port;
        logic       we;
        logic [7:0] data;
    } exp_t;

    exp_t       sb_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_rd0 = '0;
    logic [7:0] exp_rd1 = '0;
    bit         mon_en = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (mon_en && !rst) begin
            if (m0_ack || m1_ack) begin
                check_eq("ack_onehot", 32'(m0_ack & m1_ack), 0);
                check_eq("sb_nonempty", 32'(sb_q.size() != 0), 1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check_eq("ack_port", 32'(m1_ack), 32'(e.port));
                    if (!e.we) begin
                        if (e.port) exp_rd1 = e.data;
                        else        exp_rd0 = e.data;
                    end
                end
            end
            check_eq("m0_rdata", m0_rdata, exp_rd0);
            check_eq("m1_rdata", m1_rdata, exp_rd1);
        end
    end

    task automatic push_exp(input bit port, input bit we, input logic [7:0] addr, input logic [7:0] wdata);
        sb_q.push_back('{port: port, we: we, data: (we ? 8'h00 : ref_mem[addr])});
        if (we) ref_mem[addr] = wdata;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        m0_req = 1'b0;
        m1_req = 1'b0;
        sb_q.delete();
        exp_rd0 = '0;
        exp_rd1 = '0;
        #1;
        check_eq("rst_mem_we", 32'(mem_we), 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_mem_in", mem_in, 0);
        check_eq("rst_acks", {m0_ack, m1_ack}, 0);
        check_eq("rst_rdata", {m0_rdata, m1_rdata}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;
    endtask

    // One access by a single requester; addr_acc is applied to the port during ACC.
    task automatic access(input bit port, input bit we, input logic [7:0] addr,
                          input logic [7:0] wdata, input logic [7:0] addr_acc);
        int lat;
        bit got;
        @(negedge clk);
        if (port) begin
            m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata;
        end else begin
            m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata;
        end
        push_exp(port, we, addr, wdata);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 8) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                check_eq("acc_we", 32'(mem_we), 32'(we));
                check_eq("acc_addr", mem_addr, addr);
                if (we) check_eq("acc_wdata", mem_in, wdata);
                if (port) m1_addr = addr_acc;
                else      m0_addr = addr_acc;
            end
            if (lat == 2) check_eq("ack_mem_we", 32'(mem_we), 0);
            got = port ? m1_ack : m0_ack;
        end
        check_eq("ack_latency", lat, 2);
        if (port) m1_req = 1'b0;
        else      m0_req = 1'b0;
    endtask

    task automatic both_read(input int n_grants, input int lock_release_at);
        int n;
        int cyc;
        @(negedge clk);
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 8'h17;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 8'hA0;
        n = 0;
        cyc = 0;
        while (n < n_grants && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (m0_ack || m1_ack) begin
                n++;
`ifdef MEM_ARB_LOCK_EN
                if (n == lock_release_at) m0_lock = 1'b0;
`endif
            end
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        check_eq("grant_count", n, n_grants);
        repeat (4) @(negedge clk);
        check_eq("sb_drained_pair", sb_q.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);

        // Write then read back by the CPU port.
        do_reset();
        access(1'b0, 1'b1, 8'h05, 8'h2A, 8'h05);
        access(1'b0, 1'b0, 8'h05, 8'h00, 8'h05);

        // Continuous competing reads alternate m0, m1, m0 from reset.
        do_reset();
        push_exp(1'b0, 1'b0, 8'h17, 8'h00);
        push_exp(1'b1, 1'b0, 8'hA0, 8'h00);
        push_exp(1'b0, 1'b0, 8'h17, 8'h00);
        both_read(3, 0);

        // Lone auxiliary read; m0 rdata must stay put.
        access(1'b1, 1'b0, 8'h10, 8'h00, 8'h10);

        // Reset during ACC of an m1 write aborts it.
        @(negedge clk);
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 8'h30; m1_wdata = 8'hE7;
        @(negedge clk);
        check_eq("t4_acc_we", 32'(mem_we), 1);
        rst = 1'b1;
        exp_rd0 = '0;
        exp_rd1 = '0;
        #1;
        check_eq("t4_we_dropped", 32'(mem_we), 0);
        check_eq("t4_no_ack", {m0_ack, m1_ack}, 0);
        m1_req = 1'b0;
        @(negedge clk);
        check_eq("t4_mem_kept", mem[8'h30], ref_mem[8'h30]);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("t4_no_late_ack", {m0_ack, m1_ack}, 0);
        end
        access(1'b1, 1'b0, 8'h30, 8'h00, 8'h30);

        // Address change during ACC is ignored.
        access(1'b0, 1'b0, 8'h40, 8'h00, 8'h41);
        access(1'b1, 1'b1, 8'h41, 8'h66, 8'h41);
        access(1'b1, 1'b0, 8'h41, 8'h00, 8'h41);

`ifdef MEM_ARB_LOCK_EN
        do_reset();
        m0_lock = 1'b1;
        push_exp(1'b0, 1'b0, 8'h17, 8'h00);
        push_exp(1'b0, 1'b0, 8'h17, 8'h00);
        push_exp(1'b0, 1'b0, 8'h17, 8'h00);
        push_exp(1'b1, 1'b0, 8'hA0, 8'h00);
        both_read(4, 3);
`endif

        repeat (5) @(negedge clk);
        check_eq("sb_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
